// File: rtl/select_buf.sv
// Elastic select stage: joins condition/true_value/false_value, forwards the
// chosen operand through a 2-slot registered FIFO (head drives result).
module select_buf #(
  parameter int DATA_TYPE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 condition,
  input  logic                 condition_valid,
  output logic                 condition_ready,
  input  logic [DATA_TYPE-1:0] true_value,
  input  logic                 true_value_valid,
  output logic                 true_value_ready,
  input  logic [DATA_TYPE-1:0] false_value,
  input  logic                 false_value_valid,
  output logic                 false_value_ready,
  output logic [DATA_TYPE-1:0] result,
  output logic                 result_valid,
  input  logic                 result_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [DATA_TYPE-1:0] head_reg, head_next;
  logic [DATA_TYPE-1:0] tail_reg, tail_next;

  logic                 space;
  logic                 all_v;
  logic                 push;
  logic                 pop;
  logic [DATA_TYPE-1:0] sel_data;

  // space comes only from registered state; rst gating keeps every ready low
  // while the buffer is held in reset.
  assign space = rst & (state_reg != TWO);
  assign all_v = condition_valid & true_value_valid & false_value_valid;

  assign condition_ready   = space & true_value_valid & false_value_valid;
  assign true_value_ready  = space & condition_valid & false_value_valid;
  assign false_value_ready = space & condition_valid & true_value_valid;

  assign push     = space & all_v;
  assign sel_data = condition ? true_value : false_value;

  assign result_valid = (state_reg != EMPTY);
  assign result       = head_reg;
  assign pop          = result_valid & result_ready;

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    case (state_reg)
      EMPTY: begin
        if (push) begin
          head_next  = sel_data;
          state_next = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_next = sel_data;
        end else if (push) begin
          tail_next  = sel_data;
          state_next = TWO;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        // Full: no push possible, a pop promotes the tail to the head.
        if (pop) begin
          head_next  = tail_reg;
          state_next = ONE;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

endmodule
